// File: rtl/dll_loop_filter_if.sv
// Vote inputs and code/lock/saturation outputs of the DLL loop filter.
// The master side drives votes; the slave side is the filter.
interface dll_loop_filter_if #(
    parameter int CODE_W = 6
);
    logic              en_i;
    logic              up_i;
    logic              down_i;
    logic [CODE_W-1:0] code_o;
    logic              lock_o;
    logic              sat_hi_o;
    logic              sat_lo_o;

    modport master (
        output en_i, up_i, down_i,
        input  code_o, lock_o, sat_hi_o, sat_lo_o
    );

    modport slave (
        input  en_i, up_i, down_i,
        output code_o, lock_o, sat_hi_o, sat_lo_o
    );
endinterface

// File: rtl/dll_loop_filter.sv
// DLL loop filter: integrates UP/DOWN votes into a saturating delay code and flags lock.
// The code steps on the same edge that samples the FILT_TH-th net vote; en_i=0 freezes all state.
module dll_loop_filter #(
    parameter int CODE_W    = 6,
    parameter int CODE_INIT = 32,
    parameter int FILT_TH   = 4,
    parameter int LOCK_REV  = 8
) (
    input  logic            clk_i,
    input  logic            rst_i,
    dll_loop_filter_if.slave bus
);
    typedef enum logic [1:0] {DIR_NONE, DIR_UP, DIR_DN} dir_t;

    localparam logic [CODE_W-1:0] CODE_MAX  = '1;
    localparam logic [CODE_W-1:0] CODE_RST  = CODE_W'(CODE_INIT);
    localparam logic [CODE_W-1:0] CODE_ONE  = CODE_W'(1);
    localparam logic signed [7:0] TH_P      = 8'(FILT_TH);
    localparam logic signed [7:0] TH_N      = -TH_P;
    localparam logic [7:0]        REV_MAX   = 8'(LOCK_REV);

    logic signed [7:0] acc;
    logic signed [7:0] vote;
    logic signed [7:0] acc_sum;
    logic [CODE_W-1:0] code_q;
    logic [CODE_W-1:0] code_nxt;
    logic [7:0]        rev_cnt;
    logic [7:0]        rev_inc;
    dir_t              last_dir;
    dir_t              step_dir;
    logic              step_up;
    logic              step_dn;
    logic              blocked;
    logic              lock_q;
    logic              sat_hi_q;
    logic              sat_lo_q;

    always_comb begin
        vote = 8'sd0;
        if (bus.up_i && !bus.down_i)
            vote = 8'sd1;
        else if (!bus.up_i && bus.down_i)
            vote = -8'sd1;
        acc_sum  = acc + vote;
        step_up  = (acc_sum == TH_P);
        step_dn  = (acc_sum == TH_N);
        step_dir = step_up ? DIR_UP : DIR_DN;
        blocked  = (step_up && code_q == CODE_MAX) || (step_dn && code_q == '0);
        code_nxt = code_q;
        if (step_up && !blocked)
            code_nxt = code_q + CODE_ONE;
        else if (step_dn && !blocked)
            code_nxt = code_q - CODE_ONE;
        rev_inc = (rev_cnt >= REV_MAX) ? REV_MAX : rev_cnt + 8'd1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            acc      <= 8'sd0;
            code_q   <= CODE_RST;
            rev_cnt  <= 8'd0;
            last_dir <= DIR_NONE;
            lock_q   <= 1'b0;
            sat_hi_q <= (CODE_RST == CODE_MAX);
            sat_lo_q <= (CODE_RST == '0);
        end else if (bus.en_i) begin
            acc      <= (step_up || step_dn) ? 8'sd0 : acc_sum;
            code_q   <= code_nxt;
            sat_hi_q <= (code_nxt == CODE_MAX);
            sat_lo_q <= (code_nxt == '0);
            if (step_up || step_dn) begin
                // A blocked step means the loop is pinned at a rail, never locked.
                if (blocked) begin
                    rev_cnt  <= 8'd0;
                    lock_q   <= 1'b0;
                    last_dir <= step_dir;
                end else if (last_dir == DIR_NONE) begin
                    last_dir <= step_dir;
                end else if (last_dir != step_dir) begin
                    rev_cnt  <= rev_inc;
                    last_dir <= step_dir;
                    if (rev_inc == REV_MAX)
                        lock_q <= 1'b1;
                end else begin
                    rev_cnt <= 8'd0;
                    lock_q  <= 1'b0;
                end
            end
        end
    end

    assign bus.code_o   = code_q;
    assign bus.lock_o   = lock_q;
    assign bus.sat_hi_o = sat_hi_q;
    assign bus.sat_lo_o = sat_lo_q;
endmodule

// File: tb/tb_dll_loop_filter.sv
// Directed bench for dll_loop_filter with hand-computed expected codes and lock flags.
module tb_dll_loop_filter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    dll_loop_filter_if #(.CODE_W(6)) bus();

    dll_loop_filter #(
        .CODE_W(6), .CODE_INIT(32), .FILT_TH(4), .LOCK_REV(8)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic vote(input logic u, input logic d, input logic e);
        bus.en_i = e; bus.up_i = u; bus.down_i = d;
        @(posedge clk); #1;
    endtask

    task automatic votes(input logic u, input logic d, input int n);
        for (int i = 0; i < n; i++) vote(u, d, 1'b1);
    endtask

    task automatic do_reset();
        rst = 1'b1; #3; rst = 1'b0;
        bus.en_i = 1'b1; bus.up_i = 1'b0; bus.down_i = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        bus.en_i = 1'b1; bus.up_i = 1'b0; bus.down_i = 1'b0;
        #12; rst = 1'b0;
        @(posedge clk); #1;
        checks++; if (bus.code_o !== 6'd32) begin errors++; $display("FAIL rst_code got=%0d exp=32", bus.code_o); end
        votes(1'b1, 1'b0, 4);
        checks++; if (bus.code_o !== 6'd33) begin errors++; $display("FAIL pre_rst_code got=%0d exp=33", bus.code_o); end
        // assert reset between edges and look before any clock edge
        rst = 1'b1; #2;
        checks++; if (bus.code_o !== 6'd32) begin errors++; $display("FAIL async_rst_code got=%0d exp=32", bus.code_o); end
        checks++; if ({bus.lock_o, bus.sat_hi_o, bus.sat_lo_o} !== 3'b000) begin errors++; $display("FAIL async_rst_flags got=%b exp=000", {bus.lock_o, bus.sat_hi_o, bus.sat_lo_o}); end
        do_reset();
    endtask

    task automatic test_filtering();
        votes(1'b1, 1'b0, 3);
        checks++; if (bus.code_o !== 6'd32) begin errors++; $display("FAIL filt_3votes got=%0d exp=32", bus.code_o); end
        vote(1'b1, 1'b0, 1'b1);
        checks++; if (bus.code_o !== 6'd33) begin errors++; $display("FAIL filt_step got=%0d exp=33", bus.code_o); end
        vote(1'b1, 1'b0, 1'b1); vote(1'b0, 1'b1, 1'b1);
        vote(1'b1, 1'b0, 1'b1); vote(1'b0, 1'b1, 1'b1);
        vote(1'b1, 1'b1, 1'b1); vote(1'b0, 1'b0, 1'b1);
        checks++; if (bus.code_o !== 6'd33) begin errors++; $display("FAIL filt_mixed got=%0d exp=33", bus.code_o); end
    endtask

    task automatic test_en_gaps();
        votes(1'b0, 1'b1, 3);
        checks++; if (bus.code_o !== 6'd33) begin errors++; $display("FAIL dn_3votes got=%0d exp=33", bus.code_o); end
        for (int i = 0; i < 5; i++) begin
            vote(1'b0, 1'b1, 1'b0);
            checks++; if (bus.code_o !== 6'd33) begin errors++; $display("FAIL en_hold[%0d] got=%0d exp=33", i, bus.code_o); end
        end
        vote(1'b0, 1'b1, 1'b1);
        checks++; if (bus.code_o !== 6'd32) begin errors++; $display("FAIL dn_step got=%0d exp=32", bus.code_o); end
    endtask

    task automatic test_saturation();
        votes(1'b1, 1'b0, 124);
        checks++; if (bus.code_o !== 6'd63) begin errors++; $display("FAIL sat_hi_code got=%0d exp=63", bus.code_o); end
        checks++; if (bus.sat_hi_o !== 1'b1) begin errors++; $display("FAIL sat_hi_flag got=%b exp=1", bus.sat_hi_o); end
        votes(1'b1, 1'b0, 4);
        checks++; if (bus.code_o !== 6'd63 || bus.lock_o !== 1'b0) begin errors++; $display("FAIL sat_hi_blocked code=%0d lock=%b exp=63/0", bus.code_o, bus.lock_o); end
        votes(1'b0, 1'b1, 4);
        checks++; if (bus.code_o !== 6'd62 || bus.sat_hi_o !== 1'b0) begin errors++; $display("FAIL sat_hi_leave code=%0d sat_hi=%b exp=62/0", bus.code_o, bus.sat_hi_o); end
        do_reset();
        votes(1'b0, 1'b1, 128);
        checks++; if (bus.code_o !== 6'd0 || bus.sat_lo_o !== 1'b1) begin errors++; $display("FAIL sat_lo code=%0d sat_lo=%b exp=0/1", bus.code_o, bus.sat_lo_o); end
        votes(1'b0, 1'b1, 4);
        checks++; if (bus.code_o !== 6'd0 || bus.lock_o !== 1'b0) begin errors++; $display("FAIL sat_lo_blocked code=%0d lock=%b exp=0/0", bus.code_o, bus.lock_o); end
        votes(1'b1, 1'b0, 4);
        checks++; if (bus.code_o !== 6'd1 || bus.sat_lo_o !== 1'b0) begin errors++; $display("FAIL sat_lo_leave code=%0d sat_lo=%b exp=1/0", bus.code_o, bus.sat_lo_o); end
    endtask

    task automatic test_lock();
        logic [5:0] exp_code;
        logic       exp_lock;
        do_reset();
        // step 1 sets the direction; steps 2..9 are the 8 reversals
        for (int s = 1; s <= 9; s++) begin
            votes(s % 2 == 1, s % 2 == 0, 4);
            exp_code = (s % 2 == 1) ? 6'd33 : 6'd32;
            exp_lock = (s == 9);
            checks++; if (bus.code_o !== exp_code || bus.lock_o !== exp_lock) begin errors++; $display("FAIL lock_step%0d code=%0d lock=%b exp=%0d/%b", s, bus.code_o, bus.lock_o, exp_code, exp_lock); end
        end
        votes(1'b0, 1'b1, 4);
        checks++; if (bus.code_o !== 6'd32 || bus.lock_o !== 1'b1) begin errors++; $display("FAIL lock_keep code=%0d lock=%b exp=32/1", bus.code_o, bus.lock_o); end
        votes(1'b0, 1'b1, 4);
        checks++; if (bus.code_o !== 6'd31 || bus.lock_o !== 1'b0) begin errors++; $display("FAIL lock_drop code=%0d lock=%b exp=31/0", bus.code_o, bus.lock_o); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        votes(1'b1, 1'b0, 32);
        for (int s = 0; s < 8; s++) votes(s % 2 == 1, s % 2 == 0, 4);
        checks++; if (bus.code_o !== 6'd40 || bus.lock_o !== 1'b1) begin errors++; $display("FAIL mid_setup code=%0d lock=%b exp=40/1", bus.code_o, bus.lock_o); end
        votes(1'b1, 1'b0, 3);
        checks++; if (bus.code_o !== 6'd40) begin errors++; $display("FAIL mid_acc3 got=%0d exp=40", bus.code_o); end
        rst = 1'b1; #2;
        checks++; if (bus.code_o !== 6'd32 || bus.lock_o !== 1'b0) begin errors++; $display("FAIL mid_rst code=%0d lock=%b exp=32/0", bus.code_o, bus.lock_o); end
        rst = 1'b0;
        @(posedge clk); #1;
        vote(1'b1, 1'b0, 1'b1);
        checks++; if (bus.code_o !== 6'd32) begin errors++; $display("FAIL mid_acc_clr got=%0d exp=32", bus.code_o); end
        votes(1'b1, 1'b0, 3);
        checks++; if (bus.code_o !== 6'd33 || bus.lock_o !== 1'b0) begin errors++; $display("FAIL mid_restep code=%0d lock=%b exp=33/0", bus.code_o, bus.lock_o); end
    endtask

    initial begin
        test_reset();
        test_filtering();
        test_en_gaps();
        test_saturation();
        test_lock();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/dll_loop_filter.md
Name: dll_loop_filter

Overview:
- Digital loop filter and delay-code integrator for the DLL. It sits directly downstream of the UP/DOWN lock-select stage.
- Consumes the selected UP/DOWN votes and low-pass filters them with a signed vote accumulator.
- Steps a saturating delay-line control code and reports lock once the code dithers about a stable value.

Parameters:
- CODE_W, 6, width of delay-line control code.
- CODE_INIT, 32, code value after reset (must be < 2^CODE_W).
- FILT_TH, 4, net votes needed for one code step (2..127).
- LOCK_REV, 8, consecutive direction reversals required to assert lock (1..255).

Ports:
- clk_i  input  1  loop clock; all state updates on its rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- en_i  input  1  1 = filter runs; 0 = all state held, votes ignored.
- up_i  input  1  UP vote from lock select (request more delay).
- down_i  input  1  DOWN vote from lock select (request less delay).
- code_o  output  CODE_W  registered delay-line control code.
- lock_o  output  1  registered lock indication.
- sat_hi_o  output  1  registered; 1 when code_o == 2^CODE_W-1.
- sat_lo_o  output  1  registered; 1 when code_o == 0.

Behaviour:
- Reset (async, rst_i=1) forces all state immediately, and holds it while rst_i is high:
  - code_o=CODE_INIT, acc=0, rev_cnt=0, last_dir=NONE, lock_o=0.
  - sat_hi_o/sat_lo_o reflect CODE_INIT.
- Reset mid-operation discards the accumulator and lock history with no partial step.
- Vote decode each edge with en_i=1:
  - up_i=1, down_i=0 -> +1.
  - up_i=0, down_i=1 -> -1.
  - 00 or 11 -> 0; no state change.
- Accumulator acc is signed, range -(FILT_TH-1)..+(FILT_TH-1):
  - next = acc + vote.
  - If next == +FILT_TH: acc <= 0 and request step UP.
  - If next == -FILT_TH: acc <= 0 and request step DN.
  - Otherwise acc <= next.
- Step latency: code_o changes on the same edge that samples the FILT_TH-th net vote. It is visible one cycle after that vote is presented.
- Code update:
  - UP: code+1. DN: code-1.
  - Saturating: UP at max or DN at 0 leaves code unchanged (a "blocked step"). acc is still cleared.
- Lock tracking, evaluated on every requested step (blocked or not):
  - Blocked step: rev_cnt <= 0, lock_o <= 0, last_dir <= step dir.
  - last_dir == NONE: last_dir <= dir, rev_cnt unchanged (0).
  - dir opposite to last_dir: rev_cnt <= min(rev_cnt+1, LOCK_REV); last_dir <= dir.
  - dir same as last_dir: rev_cnt <= 0, lock_o <= 0.
  - lock_o <= 1 on the edge at which rev_cnt becomes LOCK_REV. It stays 1 until a same-direction step, a blocked step, or reset.
- sat_hi_o/sat_lo_o are registered copies of the next-code comparisons and update in the same cycle as code_o.
- en_i=0:
  - acc, code, rev_cnt, last_dir, lock_o hold; votes ignored.
  - Deasserting and reasserting en_i does not clear the accumulator.
- No glitches: all outputs come from flops.

Test Plan:
- Reset: assert rst_i asynchronously between edges -> code_o=32, lock_o=0, sat_hi_o=0, sat_lo_o=0 immediately, with no clock required.
- Filtering: 4 consecutive UP votes (10) -> code_o 32->33 on the 4th sampling edge. Then UP,DOWN,UP,DOWN,11,00 -> code_o stays 33, acc returns to 0.
- Down path with en_i gaps: 3 DOWN votes, en_i=0 for 5 cycles while driving DOWN, then 1 DOWN with en_i=1 -> code_o 33->32 only on that last edge.
- Saturation:
  - Preload via 124 UP votes from 32 -> code_o=63, sat_hi_o=1.
  - 4 more UP votes -> code_o stays 63, lock_o=0.
  - 4 DOWN votes -> 62, sat_hi_o=0.
- Lock: alternate groups of 4 UP / 4 DOWN votes -> code toggles 32/33. lock_o rises on the edge of the 8th reversal. Two same-direction steps then drop lock_o on the second step's edge.
- Reset mid-operation: with lock_o=1, code_o=40, acc=+3, pulse rst_i -> code_o=32, lock_o=0. The next single UP vote does not step the code (acc cleared).
